// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up and initialisation sequencer: RESET#, CKE, per-rank MRS and ZQCL for 1-4 ranks.
// Define DDR3_INIT_FASTSIM_EN to clamp the reset and CKE waits to at most 8 cycles.
module ddr3_init_sequencer #(
    parameter int          NUM_RANKS = 1,
    parameter int          ROW_WIDTH = 14,
    parameter int          T_RESET   = 100000,
    parameter int          T_CKE     = 250000,
    parameter int          T_XPR     = 90,
    parameter int          T_MRD     = 4,
    parameter int          T_MOD     = 12,
    parameter int          T_ZQINIT  = 512,
    parameter logic [15:0] MR0_VAL   = 16'h0,
    parameter logic [15:0] MR1_VAL   = 16'h0,
    parameter logic [15:0] MR2_VAL   = 16'h0,
    parameter logic [15:0] MR3_VAL   = 16'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reinit,
    output logic                 ddr_reset_n,
    output logic                 cke,
    output logic [NUM_RANKS-1:0] cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [2:0]           ba,
    output logic [ROW_WIDTH-1:0] addr,
    output logic                 busy,
    output logic                 init_done
);

`ifdef DDR3_INIT_FASTSIM_EN
    localparam int T_RESET_EFF = (T_RESET < 8) ? T_RESET : 8;
    localparam int T_CKE_EFF   = (T_CKE < 8) ? T_CKE : 8;
`else
    localparam int T_RESET_EFF = T_RESET;
    localparam int T_CKE_EFF   = T_CKE;
`endif

    localparam int MAX_A = (T_RESET_EFF > T_CKE_EFF) ? T_RESET_EFF : T_CKE_EFF;
    localparam int MAX_B = (MAX_A > T_XPR) ? MAX_A : T_XPR;
    localparam int MAX_C = (MAX_B > T_MRD) ? MAX_B : T_MRD;
    localparam int MAX_D = (MAX_C > T_MOD) ? MAX_C : T_MOD;
    localparam int T_MAX = (MAX_D > T_ZQINIT) ? MAX_D : T_ZQINIT;
    localparam int CNT_W = $clog2(T_MAX) + 1;

    localparam logic [3:0] LAST_STEP = 4'(4 * NUM_RANKS - 1);

    typedef enum logic [3:0] {
        RST_HOLD, CKE_WAIT, XPR_WAIT, MRS, MRS_GAP, MOD_WAIT, ZQCL, ZQ_WAIT, DONE
    } state_t;

    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [3:0]           step, step_next;
    logic                 last_step;
    logic [CNT_W-1:0]     next_mrs_load;

    logic                 ddr_reset_n_d, cke_d, ras_n_d, cas_n_d, we_n_d, busy_d, init_done_d;
    logic [NUM_RANKS-1:0] cs_n_d;
    logic [2:0]           ba_d;
    logic [ROW_WIDTH-1:0] addr_d;

    // The counter loaded on entry to an MRS covers the gap to whatever follows it.
    assign last_step     = (step == LAST_STEP);
    assign next_mrs_load = ((step + 4'd1) == LAST_STEP) ? CNT_W'(T_MOD - 1) : CNT_W'(T_MRD - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RST_HOLD;
            cnt         <= CNT_W'(T_RESET_EFF);
            step        <= '0;
            ddr_reset_n <= 1'b0;
            cke         <= 1'b0;
            cs_n        <= '1;
            ras_n       <= 1'b1;
            cas_n       <= 1'b1;
            we_n        <= 1'b1;
            ba          <= '0;
            addr        <= '0;
            busy        <= 1'b1;
            init_done   <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            step        <= step_next;
            ddr_reset_n <= ddr_reset_n_d;
            cke         <= cke_d;
            cs_n        <= cs_n_d;
            ras_n       <= ras_n_d;
            cas_n       <= cas_n_d;
            we_n        <= we_n_d;
            ba          <= ba_d;
            addr        <= addr_d;
            busy        <= busy_d;
            init_done   <= init_done_d;
        end
    end

    always_comb begin
        next_state = state;
        step_next  = step;
        cnt_next   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
        case (state)
            RST_HOLD: if (cnt == '0) begin
                next_state = CKE_WAIT;
                cnt_next   = CNT_W'(T_CKE_EFF - 1);
            end
            CKE_WAIT: if (cnt == '0) begin
                next_state = XPR_WAIT;
                cnt_next   = CNT_W'(T_XPR - 1);
            end
            XPR_WAIT: if (cnt == '0) begin
                next_state = MRS;
                step_next  = '0;
                cnt_next   = CNT_W'(T_MRD - 1);
            end
            MRS: begin
                if (cnt != '0) begin
                    next_state = last_step ? MOD_WAIT : MRS_GAP;
                end else if (last_step) begin
                    next_state = ZQCL;
                    cnt_next   = CNT_W'(T_ZQINIT - 1);
                end else begin
                    next_state = MRS;
                    step_next  = step + 4'd1;
                    cnt_next   = next_mrs_load;
                end
            end
            MRS_GAP: if (cnt == '0) begin
                next_state = MRS;
                step_next  = step + 4'd1;
                cnt_next   = next_mrs_load;
            end
            MOD_WAIT: if (cnt == '0) begin
                next_state = ZQCL;
                cnt_next   = CNT_W'(T_ZQINIT - 1);
            end
            ZQCL:    next_state = (cnt == '0) ? DONE : ZQ_WAIT;
            ZQ_WAIT: if (cnt == '0) next_state = DONE;
            DONE: if (reinit) begin
                next_state = RST_HOLD;
                cnt_next   = CNT_W'(T_RESET_EFF - 1);
            end
            default: next_state = RST_HOLD;
        endcase
    end

    // Outputs are decoded from the upcoming state so they change on the same edge as the state.
    always_comb begin
        ddr_reset_n_d = 1'b1;
        cke_d         = 1'b1;
        cs_n_d        = '1;
        ras_n_d       = 1'b1;
        cas_n_d       = 1'b1;
        we_n_d        = 1'b1;
        ba_d          = '0;
        addr_d        = '0;
        busy_d        = 1'b1;
        init_done_d   = 1'b0;
        case (next_state)
            RST_HOLD: begin
                ddr_reset_n_d = 1'b0;
                cke_d         = 1'b0;
            end
            CKE_WAIT: cke_d = 1'b0;
            MRS: begin
                for (int r = 0; r < NUM_RANKS; r++) begin
                    if (step_next[3:2] == 2'(r)) cs_n_d[r] = 1'b0;
                end
                ras_n_d = 1'b0;
                cas_n_d = 1'b0;
                we_n_d  = 1'b0;
                case (step_next[1:0])
                    2'd0: begin ba_d = 3'd2; addr_d = MR2_VAL[ROW_WIDTH-1:0]; end
                    2'd1: begin ba_d = 3'd3; addr_d = MR3_VAL[ROW_WIDTH-1:0]; end
                    2'd2: begin ba_d = 3'd1; addr_d = MR1_VAL[ROW_WIDTH-1:0]; end
                    default: begin ba_d = 3'd0; addr_d = MR0_VAL[ROW_WIDTH-1:0]; end
                endcase
            end
            ZQCL: begin
                cs_n_d     = '0;
                we_n_d     = 1'b0;
                addr_d[10] = 1'b1;
            end
            DONE: begin
                busy_d      = 1'b0;
                init_done_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Bench for ddr3_init_sequencer: a one-rank and a two-rank instance run side by side under random
// reinit/reset traffic and are compared every cycle with a timeline model computed from event offsets.
module tb_ddr3_init_sequencer;

    localparam int T_RESET  = 10;
    localparam int T_CKE    = 20;
    localparam int T_XPR    = 5;
    localparam int T_MRD    = 4;
    localparam int T_MOD    = 12;
    localparam int T_ZQINIT = 64;

`ifdef DDR3_INIT_FASTSIM_EN
    localparam int E_RESET = 8;
    localparam int E_CKE   = 8;
    localparam int SHIFT   = 14;
`else
    localparam int E_RESET = T_RESET;
    localparam int E_CKE   = T_CKE;
    localparam int SHIFT   = 0;
`endif

    localparam logic [15:0] A_MR0 = 16'h0520, A_MR1 = 16'h0044, A_MR2 = 16'h0018, A_MR3 = 16'h0004;
    localparam logic [15:0] B_MR0 = 16'hC123, B_MR1 = 16'h4006, B_MR2 = 16'h8208, B_MR3 = 16'hFFFF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reinit = 1'b0;

    logic        rn_a, cke_a, ras_a, cas_a, we_a, busy_a, done_a;
    logic [0:0]  cs_a;
    logic [2:0]  ba_a;
    logic [13:0] addr_a;
    logic        rn_b, cke_b, ras_b, cas_b, we_b, busy_b, done_b;
    logic [1:0]  cs_b;
    logic [2:0]  ba_b;
    logic [13:0] addr_b;

    int n_checks = 0;
    int n_fail = 0;
    int t_a = -1;
    int t_b = -1;

    always #5 clk = ~clk;

    ddr3_init_sequencer #(
        .NUM_RANKS(1), .ROW_WIDTH(14), .T_RESET(T_RESET), .T_CKE(T_CKE), .T_XPR(T_XPR),
        .T_MRD(T_MRD), .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT),
        .MR0_VAL(A_MR0), .MR1_VAL(A_MR1), .MR2_VAL(A_MR2), .MR3_VAL(A_MR3)
    ) dut_a (
        .clk(clk), .reset(reset), .reinit(reinit), .ddr_reset_n(rn_a), .cke(cke_a), .cs_n(cs_a),
        .ras_n(ras_a), .cas_n(cas_a), .we_n(we_a), .ba(ba_a), .addr(addr_a), .busy(busy_a),
        .init_done(done_a)
    );

    ddr3_init_sequencer #(
        .NUM_RANKS(2), .ROW_WIDTH(14), .T_RESET(T_RESET), .T_CKE(T_CKE), .T_XPR(T_XPR),
        .T_MRD(T_MRD), .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT),
        .MR0_VAL(B_MR0), .MR1_VAL(B_MR1), .MR2_VAL(B_MR2), .MR3_VAL(B_MR3)
    ) dut_b (
        .clk(clk), .reset(reset), .reinit(reinit), .ddr_reset_n(rn_b), .cke(cke_b), .cs_n(cs_b),
        .ras_n(ras_b), .cas_n(cas_b), .we_n(we_b), .ba(ba_b), .addr(addr_b), .busy(busy_b),
        .init_done(done_b)
    );

    function automatic logic [31:0] pack(input logic rn, input logic ck, input logic [3:0] cs,
                                         input logic r, input logic c, input logic w,
                                         input logic [2:0] b, input logic [15:0] a,
                                         input logic bz, input logic dn);
        return {2'b00, rn, ck, cs, r, c, w, b, a, bz, dn};
    endfunction

    logic [31:0] obs_a, obs_b;
    assign obs_a = pack(rn_a, cke_a, {3'b111, cs_a}, ras_a, cas_a, we_a, ba_a, {2'b00, addr_a}, busy_a, done_a);
    assign obs_b = pack(rn_b, cke_b, {2'b11, cs_b}, ras_b, cas_b, we_b, ba_b, {2'b00, addr_b}, busy_b, done_b);

    localparam logic [31:0] RESET_PACK = {2'b00, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0, 1'b1, 1'b0};

    function automatic int doneTime(input int nr);
        return E_RESET + E_CKE + T_XPR + (4 * nr - 1) * T_MRD + T_MOD + T_ZQINIT;
    endfunction

    // Expected pins t cycles after the sequence origin, derived purely from the event offsets.
    function automatic logic [31:0] expectOut(input int nr, input int t, input logic [15:0] mr0,
                                              input logic [15:0] mr1, input logic [15:0] mr2,
                                              input logic [15:0] mr3);
        int t_cke, t_mrs, t_last, t_zq, t_done, idx, mr;
        logic rn, ck, r, c, w;
        logic [3:0] cs;
        logic [2:0] b;
        logic [15:0] a;
        t_cke  = E_RESET + E_CKE;
        t_mrs  = t_cke + T_XPR;
        t_last = t_mrs + (4 * nr - 1) * T_MRD;
        t_zq   = t_last + T_MOD;
        t_done = t_zq + T_ZQINIT;
        rn = (t >= E_RESET);
        ck = (t >= t_cke);
        cs = 4'hF; r = 1'b1; c = 1'b1; w = 1'b1; b = 3'd0; a = 16'h0;
        if (t >= t_mrs && t <= t_last && ((t - t_mrs) % T_MRD) == 0) begin
            idx = (t - t_mrs) / T_MRD;
            case (idx % 4)
                0: mr = 2;
                1: mr = 3;
                2: mr = 1;
                default: mr = 0;
            endcase
            cs[idx / 4] = 1'b0;
            r = 1'b0; c = 1'b0; w = 1'b0;
            b = 3'(mr);
            case (mr)
                0: a = mr0 & 16'h3FFF;
                1: a = mr1 & 16'h3FFF;
                2: a = mr2 & 16'h3FFF;
                default: a = mr3 & 16'h3FFF;
            endcase
        end else if (t == t_zq) begin
            for (int i = 0; i < nr; i++) cs[i] = 1'b0;
            w = 1'b0;
            a = 16'h0400;
        end
        return pack(rn, ck, cs, r, c, w, b, a, (t < t_done), (t >= t_done));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h at time %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance each model clock at the edge, then compare just after it.
    always @(posedge clk) begin
        if (!reset) begin
            t_a = -1;
            t_b = -1;
        end else begin
            t_a = (reinit && t_a >= doneTime(1)) ? 0 : t_a + 1;
            t_b = (reinit && t_b >= doneTime(2)) ? 0 : t_b + 1;
        end
        #1;
        checkOutput($sformatf("a_pins_t%0d", t_a), obs_a, expectOut(1, t_a, A_MR0, A_MR1, A_MR2, A_MR3));
        checkOutput($sformatf("b_pins_t%0d", t_b), obs_b, expectOut(2, t_b, B_MR0, B_MR1, B_MR2, B_MR3));
        if (t_a == 9 - SHIFT / 7)  checkOutput("a_rst_low",   32'(rn_a), 32'd0);
        if (t_a == 10 - SHIFT / 7) checkOutput("a_rst_rise",  32'(rn_a), 32'd1);
        if (t_a == 29 - SHIFT)     checkOutput("a_cke_low",   32'(cke_a), 32'd0);
        if (t_a == 30 - SHIFT)     checkOutput("a_cke_rise",  32'(cke_a), 32'd1);
        if (t_a == 35 - SHIFT)     checkOutput("a_mr2_ba",    32'(ba_a), 32'd2);
        if (t_a == 39 - SHIFT)     checkOutput("a_mr3_ba",    32'(ba_a), 32'd3);
        if (t_a == 43 - SHIFT)     checkOutput("a_mr1_ba",    32'(ba_a), 32'd1);
        if (t_a == 47 - SHIFT)     checkOutput("a_mr0_addr",  32'(addr_a), 32'h0520);
        if (t_a == 59 - SHIFT)     checkOutput("a_zq_addr",   32'(addr_a), 32'h0400);
        if (t_a == 122 - SHIFT)    checkOutput("a_done_low",  32'(done_a), 32'd0);
        if (t_a == 123 - SHIFT)    checkOutput("a_done_rise", 32'({done_a, busy_a}), 32'b10);
        if (t_b == 35 - SHIFT)     checkOutput("b_r0_cs",     32'(cs_b), 32'b10);
        if (t_b == 51 - SHIFT)     checkOutput("b_r1_cs",     32'(cs_b), 32'b01);
        if (t_b == 63 - SHIFT)     checkOutput("b_r1_mr0",    32'(addr_b), 32'h0123);
        if (t_b == 75 - SHIFT)     checkOutput("b_zq_cs",     32'(cs_b), 32'b00);
        if (t_b == 139 - SHIFT)    checkOutput("b_done_rise", 32'(done_b), 32'd1);
    end

    // Called on a falling edge; holds the given inputs for the given number of cycles.
    task automatic applyStimulus(input logic rst_v, input logic reinit_v, input int cycles);
        reset  = rst_v;
        reinit = reinit_v;
        if (!rst_v) begin
            #1;
            checkOutput("a_async_reset", obs_a, RESET_PACK);
            checkOutput("b_async_reset", obs_b, RESET_PACK);
        end
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 101);
        applyStimulus(1'b1, 1'b0, 99);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 50);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 40);
        applyStimulus(1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 200);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3)
                applyStimulus(1'b0, 1'b0, $urandom_range(1, 3));
            else
                applyStimulus(1'b1, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, 1);
        end
        applyStimulus(1'b1, 1'b0, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
